// File: rtl/axi_rt_cfg_bridge.sv
// axi_rt_cfg_bridge
// Connects one AXI4-Lite manager to the register-bus config port of
// axi_rt_unit_top. Only one transaction is in flight at a time.
//
//   state | meaning
//   IDLE  | waiting for an eligible AW+W pair or an AR
//   WREQ  | write presented on cfg_*, waiting for cfg_ready_i
//   RREQ  | read presented on cfg_*, waiting for cfg_ready_i
//   WRSP  | B response presented, waiting for b_ready_i
//   RRSP  | R response presented, waiting for r_ready_i
module axi_rt_cfg_bridge #(
  parameter int AddrWidth     = 32,
  parameter int RegIdWidth    = 2,
  parameter int TimeoutCycles = 0,
  parameter int CntWidth      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic [AddrWidth-1:0]  aw_addr_i,
  input  logic [RegIdWidth-1:0] aw_user_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,

  input  logic [31:0]           w_data_i,
  input  logic [3:0]            w_strb_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,

  output logic [1:0]            b_resp_o,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,

  input  logic [AddrWidth-1:0]  ar_addr_i,
  input  logic [RegIdWidth-1:0] ar_user_i,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,

  output logic [31:0]           r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,

  output logic [AddrWidth-1:0]  cfg_addr_o,
  output logic [31:0]           cfg_wdata_o,
  output logic [3:0]            cfg_wstrb_o,
  output logic                  cfg_write_o,
  output logic                  cfg_valid_o,
  input  logic [31:0]           cfg_rdata_i,
  input  logic                  cfg_error_i,
  input  logic                  cfg_ready_i,
  output logic [RegIdWidth-1:0] reg_id_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WREQ = 3'd1;
  localparam logic [2:0] S_RREQ = 3'd2;
  localparam logic [2:0] S_WRSP = 3'd3;
  localparam logic [2:0] S_RRSP = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // With the timeout disabled the compare value is unused; keep it legal.
  localparam bit                  TO_EN   = (TimeoutCycles > 0);
  localparam logic [CntWidth-1:0] TO_LAST = TO_EN ? CntWidth'(TimeoutCycles - 1) : '0;

  logic [2:0]            r_state;
  logic                  r_prio;   // 0: write wins a tie, 1: read wins
  logic [CntWidth-1:0]   r_cnt;
  logic [AddrWidth-1:0]  r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [RegIdWidth-1:0] r_id;
  logic [1:0]            r_bresp;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;

  logic w_idle;
  logic w_w_elig;
  logic w_r_elig;
  logic w_grant_w;
  logic w_grant_r;
  logic w_in_req;
  logic w_timeout;

  // Arbitration between a complete write (AW+W) and a read in IDLE.
  always_comb begin
    w_idle    = (r_state == S_IDLE);
    w_w_elig  = aw_valid_i && w_valid_i;
    w_r_elig  = ar_valid_i;
    w_grant_w = w_idle && w_w_elig && (!w_r_elig || !r_prio);
    w_grant_r = w_idle && w_r_elig && (!w_w_elig ||  r_prio);
    w_in_req  = (r_state == S_WREQ) || (r_state == S_RREQ);
    // cfg_ready_i in the last allowed cycle wins over the timeout.
    w_timeout = TO_EN && w_in_req && !cfg_ready_i && (r_cnt == TO_LAST);
  end

  // Readies are gated by reset so nothing is granted while rst_i is high.
  always_comb begin
    aw_ready_o  = !rst_i && w_grant_w;
    w_ready_o   = !rst_i && w_grant_w;
    ar_ready_o  = !rst_i && w_grant_r;
    cfg_valid_o = w_in_req;
    cfg_write_o = (r_state == S_WREQ);
    cfg_addr_o  = r_addr;
    cfg_wdata_o = r_wdata;
    cfg_wstrb_o = r_wstrb;
    reg_id_o    = r_id;
    b_valid_o   = (r_state == S_WRSP);
    b_resp_o    = r_bresp;
    r_valid_o   = (r_state == S_RRSP);
    r_data_o    = r_rdata;
    r_resp_o    = r_rresp;
  end

  // Transaction FSM with request latching, timeout counter and response capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_id    <= '0;
      r_bresp <= RESP_OKAY;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_w) begin
            r_addr  <= aw_addr_i;
            r_wdata <= w_data_i;
            r_wstrb <= w_strb_i;
            r_id    <= aw_user_i;
            r_cnt   <= '0;
            r_prio  <= ~r_prio;
            r_state <= S_WREQ;
          end else if (w_grant_r) begin
            // Reads present zero write data and strobes on the bus.
            r_addr  <= ar_addr_i;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_id    <= ar_user_i;
            r_cnt   <= '0;
            r_prio  <= ~r_prio;
            r_state <= S_RREQ;
          end
        end
        S_WREQ: begin
          if (cfg_ready_i) begin
            r_bresp <= cfg_error_i ? RESP_SLVERR : RESP_OKAY;
            r_state <= S_WRSP;
          end else if (w_timeout) begin
            r_bresp <= RESP_SLVERR;
            r_state <= S_WRSP;
          end else begin
            r_cnt <= r_cnt + CntWidth'(1);
          end
        end
        S_RREQ: begin
          if (cfg_ready_i) begin
            r_rdata <= cfg_rdata_i;
            r_rresp <= cfg_error_i ? RESP_SLVERR : RESP_OKAY;
            r_state <= S_RRSP;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_rresp <= RESP_SLVERR;
            r_state <= S_RRSP;
          end else begin
            r_cnt <= r_cnt + CntWidth'(1);
          end
        end
        S_WRSP: begin
          if (b_ready_i) r_state <= S_IDLE;
        end
        S_RRSP: begin
          if (r_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rt_cfg_bridge.sv
// Directed bench for axi_rt_cfg_bridge (TimeoutCycles = 8).
module tb_axi_rt_cfg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aw_addr;
  logic [1:0]  aw_user;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] ar_addr;
  logic [1:0]  ar_user;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic [3:0]  cfg_wstrb;
  logic        cfg_write;
  logic        cfg_valid;
  logic [31:0] cfg_rdata;
  logic        cfg_error;
  logic        cfg_ready;
  logic [1:0]  reg_id;

  int n_cmp = 0;
  int n_err = 0;

  axi_rt_cfg_bridge #(
    .AddrWidth(32), .RegIdWidth(2), .TimeoutCycles(8), .CntWidth(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_addr_i(aw_addr), .aw_user_i(aw_user), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_addr_i(ar_addr), .ar_user_i(ar_user), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
    .cfg_addr_o(cfg_addr), .cfg_wdata_o(cfg_wdata), .cfg_wstrb_o(cfg_wstrb),
    .cfg_write_o(cfg_write), .cfg_valid_o(cfg_valid),
    .cfg_rdata_i(cfg_rdata), .cfg_error_i(cfg_error), .cfg_ready_i(cfg_ready),
    .reg_id_o(reg_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  n_hi;
  bit  exp_w;

  initial begin
    rst = 1'b1;
    aw_addr = '0; aw_user = '0; aw_valid = 1'b1;
    w_data = '0; w_strb = '0; w_valid = 1'b1;
    ar_addr = '0; ar_user = '0; ar_valid = 1'b1;
    b_ready = 1'b0; r_ready = 1'b0;
    cfg_rdata = '0; cfg_error = 1'b0; cfg_ready = 1'b0;
    #3;
    // Reset state, with every request valid to confirm readies stay low
    chk("rst_aw_ready", 64'(aw_ready), 64'(0));
    chk("rst_w_ready", 64'(w_ready), 64'(0));
    chk("rst_ar_ready", 64'(ar_ready), 64'(0));
    chk("rst_cfg_valid", 64'(cfg_valid), 64'(0));
    chk("rst_b_valid", 64'(b_valid), 64'(0));
    chk("rst_r_valid", 64'(r_valid), 64'(0));
    chk("rst_cfg_addr", 64'(cfg_addr), 64'(0));
    chk("rst_reg_id", 64'(reg_id), 64'(0));
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Single write, granted on the first edge after reset release
    aw_addr = 32'h10; aw_user = 2'd1; w_data = 32'hDEADBEEF; w_strb = 4'hF;
    aw_valid = 1'b1; w_valid = 1'b1;
    #1;
    chk("wr_aw_ready", 64'(aw_ready), 64'(1));
    chk("wr_w_ready", 64'(w_ready), 64'(1));
    chk("wr_ar_ready", 64'(ar_ready), 64'(0));
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("wr_cfg_valid", 64'(cfg_valid), 64'(1));
    chk("wr_cfg_write", 64'(cfg_write), 64'(1));
    chk("wr_cfg_addr", 64'(cfg_addr), 64'h10);
    chk("wr_cfg_wdata", 64'(cfg_wdata), 64'hDEADBEEF);
    chk("wr_cfg_wstrb", 64'(cfg_wstrb), 64'hF);
    chk("wr_reg_id", 64'(reg_id), 64'd1);
    chk("wr_aw_ready_busy", 64'(aw_ready), 64'(0));
    cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0;
    chk("wr_b_valid", 64'(b_valid), 64'(1));
    chk("wr_b_resp", 64'(b_resp), 64'(0));
    chk("wr_cfg_valid_drop", 64'(cfg_valid), 64'(0));
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("wr_b_done", 64'(b_valid), 64'(0));

    // Single read with error flag
    ar_addr = 32'h20; ar_user = 2'd2; ar_valid = 1'b1;
    #1;
    chk("rd_ar_ready", 64'(ar_ready), 64'(1));
    tick();
    ar_valid = 1'b0;
    chk("rd_cfg_valid", 64'(cfg_valid), 64'(1));
    chk("rd_cfg_write", 64'(cfg_write), 64'(0));
    chk("rd_cfg_addr", 64'(cfg_addr), 64'h20);
    chk("rd_cfg_wdata", 64'(cfg_wdata), 64'(0));
    chk("rd_cfg_wstrb", 64'(cfg_wstrb), 64'(0));
    chk("rd_reg_id", 64'(reg_id), 64'd2);
    cfg_rdata = 32'h12345678; cfg_error = 1'b1; cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0; cfg_error = 1'b0;
    chk("rd_r_valid", 64'(r_valid), 64'(1));
    chk("rd_r_data", 64'(r_data), 64'h12345678);
    chk("rd_r_resp", 64'(r_resp), 64'h2);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("rd_r_done", 64'(r_valid), 64'(0));

    // Contested requests: grants alternate W,R,W,R starting with write
    aw_addr = 32'h100; aw_user = 2'd1; w_data = 32'h11112222; w_strb = 4'h3; ar_addr = 32'h200; ar_user = 2'd3;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_w = (k % 2 == 0);
      #1;
      chk("arb_aw_ready", 64'(aw_ready), 64'(exp_w));
      chk("arb_ar_ready", 64'(ar_ready), 64'(!exp_w));
      tick();
      chk("arb_cfg_write", 64'(cfg_write), 64'(exp_w));
      chk("arb_cfg_addr", 64'(cfg_addr), exp_w ? 64'h100 : 64'h200);
      cfg_ready = 1'b1;
      tick();
      cfg_ready = 1'b0;
      chk("arb_rsp_valid", 64'(exp_w ? b_valid : r_valid), 64'(1));
      tick();
    end
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;

    // Write timeout: cfg_valid high for exactly 8 cycles then SLVERR
    aw_addr = 32'h30; aw_valid = 1'b1; w_valid = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    n_hi = 0;
    for (int i = 0; i < 20 && cfg_valid; i++) begin
      n_hi++;
      tick();
    end
    chk("to_wr_cycles", 64'(n_hi), 64'd8);
    chk("to_wr_b_valid", 64'(b_valid), 64'(1));
    chk("to_wr_b_resp", 64'(b_resp), 64'h2);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;

    // cfg_ready in the 8th cycle beats the timeout
    aw_valid = 1'b1; w_valid = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("to_edge_cfg_valid", 64'(cfg_valid), 64'(1));
    cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0;
    chk("to_edge_b_valid", 64'(b_valid), 64'(1));
    chk("to_edge_b_resp", 64'(b_resp), 64'(0));
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;

    // Read timeout returns zero data with SLVERR
    cfg_rdata = 32'hAAAA5555;
    ar_addr = 32'h40; ar_valid = 1'b1;
    tick();
    ar_valid = 1'b0;
    n_hi = 0;
    for (int i = 0; i < 20 && cfg_valid; i++) begin
      n_hi++;
      tick();
    end
    chk("to_rd_cycles", 64'(n_hi), 64'd8);
    chk("to_rd_r_valid", 64'(r_valid), 64'(1));
    chk("to_rd_r_resp", 64'(r_resp), 64'h2);
    chk("to_rd_r_data", 64'(r_data), 64'(0));
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;

    // B back-pressure: response stable and AR blocked until handshake
    aw_addr = 32'h50; aw_valid = 1'b1; w_valid = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    cfg_error = 1'b1; cfg_ready = 1'b1;
    tick();
    cfg_error = 1'b0; cfg_ready = 1'b0;
    ar_addr = 32'h44; ar_user = 2'd3; ar_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_b_valid", 64'(b_valid), 64'(1));
      chk("bp_b_resp", 64'(b_resp), 64'h2);
      chk("bp_ar_ready", 64'(ar_ready), 64'(0));
      tick();
    end
    b_ready = 1'b1;
    #1;
    chk("bp_ar_ready_hs", 64'(ar_ready), 64'(0));
    tick();
    b_ready = 1'b0;
    chk("bp_b_done", 64'(b_valid), 64'(0));
    chk("bp_ar_ready_idle", 64'(ar_ready), 64'(1));
    tick();
    ar_valid = 1'b0;
    chk("rst_mid_in_rreq", 64'(cfg_valid), 64'(1));
    chk("rst_mid_addr", 64'(cfg_addr), 64'h44);

    // Asynchronous reset while in RREQ abandons the read
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_cfg_valid", 64'(cfg_valid), 64'(0));
    chk("rst_mid_cfg_addr", 64'(cfg_addr), 64'(0));
    chk("rst_mid_reg_id", 64'(reg_id), 64'(0));
    chk("rst_mid_r_valid", 64'(r_valid), 64'(0));
    cfg_ready = 1'b1; cfg_rdata = 32'hCAFEF00D;
    tick();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_post_r_valid", 64'(r_valid), 64'(0));
      chk("rst_post_cfg_valid", 64'(cfg_valid), 64'(0));
    end
    cfg_ready = 1'b0;

    // Priority bit restarts at write-first after reset
    aw_addr = 32'h60; aw_user = 2'd2; aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    #1;
    chk("post_rst_aw_ready", 64'(aw_ready), 64'(1));
    chk("post_rst_ar_ready", 64'(ar_ready), 64'(0));
    tick();
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    chk("post_rst_cfg_write", 64'(cfg_write), 64'(1));
    chk("post_rst_reg_id", 64'(reg_id), 64'd2);
    cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0;
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rt_cfg_bridge.md
AXI_RT_CFG_BRIDGE -- requirements
Module: axi_rt_cfg_bridge
Bridges a single AXI4-Lite manager to the axi_rt_unit_top register-bus config port (cfg_* plus reg_id).

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, AXI-Lite and register-bus address width.
REQ-002 SHALL have parameter RegIdWidth, default 2, width of the forwarded register-bus requester ID.
REQ-003 SHALL have parameter TimeoutCycles, default 0, register-bus ready timeout in cycles; 0 disables the timeout.
REQ-004 SHALL have parameter CntWidth, default 16, timeout counter width; TimeoutCycles SHALL be less than 2**CntWidth.
REQ-005 clk_i  input  1  clock; all state updates on the rising edge.
REQ-006 rst_i  input  1  reset, asynchronous assert, active-high.
REQ-007 aw_addr_i  input  AddrWidth  write address; aw_user_i  input  RegIdWidth  requester ID; aw_valid_i  input  1; aw_ready_o  output  1.
REQ-008 w_data_i  input  32  write data; w_strb_i  input  4  byte strobes; w_valid_i  input  1; w_ready_o  output  1.
REQ-009 b_resp_o  output  2  write response; b_valid_o  output  1; b_ready_i  input  1.
REQ-010 ar_addr_i  input  AddrWidth  read address; ar_user_i  input  RegIdWidth  requester ID; ar_valid_i  input  1; ar_ready_o  output  1.
REQ-011 r_data_o  output  32  read data; r_resp_o  output  2; r_valid_o  output  1; r_ready_i  input  1.
REQ-012 cfg_addr_o  output  AddrWidth; cfg_wdata_o  output  32; cfg_wstrb_o  output  4; cfg_write_o  output  1; cfg_valid_o  output  1.
REQ-013 cfg_rdata_i  input  32; cfg_error_i  input  1; cfg_ready_i  input  1; reg_id_o  output  RegIdWidth  ID of the current transaction.

Function
REQ-014 FSM states SHALL be IDLE, WREQ, RREQ, WRSP, RRSP; exactly one transaction SHALL be outstanding.
REQ-015 IDLE: a write is eligible only when aw_valid_i and w_valid_i are both 1; aw_ready_o and w_ready_o SHALL assert together in the same cycle, and only in IDLE.
REQ-016 IDLE: a read is eligible when ar_valid_i=1; ar_ready_o SHALL assert only in IDLE.
REQ-017 Write and read eligible in the same cycle: a priority bit picks the winner (reset value 0 = write first) and toggles after each grant; the loser SHALL see ready=0.
REQ-018 On grant, address, wdata, wstrb and user SHALL be latched; the next state is WREQ or RREQ.
REQ-019 WREQ/RREQ: cfg_valid_o=1; cfg_write_o=1 in WREQ, 0 in RREQ; cfg_addr/wdata/wstrb/reg_id SHALL hold the latched values, stable until cfg_ready_i.
REQ-020 In RREQ, cfg_wdata_o and cfg_wstrb_o SHALL be 0.
REQ-021 On cfg_ready_i=1 in WREQ: b_resp latched as 2'b10 if cfg_error_i else 2'b00; next state WRSP.
REQ-022 On cfg_ready_i=1 in RREQ: r_data latched from cfg_rdata_i and r_resp set the same way; next state RRSP.
REQ-023 WRSP/RRSP: b_valid_o/r_valid_o=1 with data held until b_ready_i/r_ready_i; the handshake cycle returns to IDLE.
REQ-024 Grant-to-cfg_valid_o latency SHALL be 1 cycle; cfg_ready-to-B/R valid latency SHALL be 1 cycle; a zero-wait write occupies 3 cycles, IDLE to IDLE.
REQ-025 In IDLE, cfg_valid_o, b_valid_o and r_valid_o SHALL be 0.
REQ-026 A request-state counter SHALL clear on entry to WREQ/RREQ and increment each cycle cfg_ready_i=0.
REQ-027 When TimeoutCycles>0 and the counter reaches TimeoutCycles-1 without cfg_ready_i: drop cfg_valid_o, respond 2'b10 (r_data=0), and enter WRSP/RRSP.
REQ-028 cfg_ready_i=1 in the timeout cycle SHALL take precedence over the timeout.
REQ-029 cfg_ready_i and cfg_error_i SHALL be ignored outside WREQ/RREQ.
REQ-030 Transactions SHALL be served in grant order; no combinational path from cfg_ready_i to any AXI ready or valid output.

Reset
REQ-031 rst_i=1 SHALL immediately force state IDLE, priority bit 0, counter 0, all valid/ready outputs 0, and latched address/data/resp/ID to 0.
REQ-032 Assertion mid-transaction SHALL abandon it; no B/R response is produced for it after reset release.
REQ-033 First grant possible in the first clock edge after rst_i deasserts.

Verification
REQ-034 Write addr 0x10, data 0xDEADBEEF, strb 0xF, user 1, cfg_ready 1 cycle later -> cfg_valid one cycle, write=1, reg_id_o=1; b_resp=00 one cycle after.
REQ-035 Read addr 0x20, cfg_rdata 0x12345678, cfg_error=1 -> r_data=0x12345678, r_resp=10.
REQ-036 Write and read both valid from IDLE for 4 back-to-back transactions -> grant order W,R,W,R.
REQ-037 TimeoutCycles=8, cfg_ready held 0 -> cfg_valid_o high exactly 8 cycles; b_resp=10; ready at cycle 8 -> OKAY.
REQ-038 b_ready_i held 0 for 5 cycles -> b_valid_o and b_resp stable; AR not accepted until B handshake.
REQ-039 rst_i pulsed while in RREQ -> all outputs 0 asynchronously; no r_valid_o after release.
